word_access_unit: RTL and testbench

WORD_ACCESS_UNIT -- requirements
Module: word_access_unit

---
 rtl/word_access_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_word_access_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_access_unit.sv
// word_access_unit: serialises one CPU word access into WORD_BYTES byte transfers on a narrow MMU port (little-endian lanes).
// Latency: 1 + 3*WORD_BYTES cycles from cpuStart to cpuDone when memBusy rises and falls one cycle apart; longer as the MMU stalls.
// Backpressure: memRequest held until memBusy accepts; cpuStart ignored while busy. Optional watchdog enabled by WORD_ACCESS_TIMEOUT_EN.
module word_access_unit #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int BUS_WIDTH      = 8,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cpuStart,
    input  logic                              cpuWrite,
    input  logic [ADDRESS_WIDTH-1:0]          cpuAddr,
    input  logic [BUS_WIDTH*WORD_BYTES-1:0]   cpuWriteData,
    output logic [BUS_WIDTH*WORD_BYTES-1:0]   cpuReadData,
    output logic                              cpuBusy,
    output logic                              cpuDone,
    output logic                              cpuError,
    output logic                              memRequest,
    output logic [ADDRESS_WIDTH-1:0]          memAddr,
    output logic                              memWriteEnable,
    output logic [BUS_WIDTH-1:0]              memDataOut,
    input  logic [BUS_WIDTH-1:0]              memDataIn,
    input  logic                              memBusy
);

    localparam int WORD_W = BUS_WIDTH * WORD_BYTES;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    // Reject parameter sets that would produce zero-width buses or a watchdog that can never wait.
    generate
        if (ADDRESS_WIDTH < 1 || BUS_WIDTH < 1 || WORD_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("word_access_unit: invalid parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        WAIT_ACCEPT = 3'd2,
        WAIT_DONE   = 3'd3,
        DONE        = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     write_q, write_d;
    logic [WORD_W-1:0]        wdata_q, wdata_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [WORD_W-1:0]        word_q, word_d;
    logic [WORD_W-1:0]        rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic last_byte;
    logic timeout_hit;

    assign last_byte = (idx_q == IDX_W'(WORD_BYTES - 1));

`ifdef WORD_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Watchdog counts cycles spent waiting on the MMU; every new byte request restarts it.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT_ACCEPT || state_q == WAIT_DONE) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The final waiting cycle is the one where the count shows TIMEOUT_CYCLES-1 already elapsed.
    assign timeout_hit = (state_q == WAIT_ACCEPT || state_q == WAIT_DONE)
                         && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the unit waits on the MMU indefinitely.
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; MMU progress takes priority over a coincident watchdog expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpuStart) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // memBusy already high counts as acceptance, so the request is not repeated.
                state_d = memBusy ? WAIT_DONE : WAIT_ACCEPT;
            end
            WAIT_ACCEPT: begin
                if (memBusy) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            WAIT_DONE: begin
                if (!memBusy) begin
                    state_d = last_byte ? DONE : ISSUE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: latch the request, assemble read lanes, and publish the read word as DONE is entered.
    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cpuStart) begin
                    addr_d  = cpuAddr;
                    write_d = cpuWrite;
                    wdata_d = cpuWriteData;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            WAIT_ACCEPT: begin
                if (!memBusy && timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!memBusy) begin
                    if (!write_q) begin
                        word_d[idx_q*BUS_WIDTH +: BUS_WIDTH] = memDataIn;
                    end
                    if (last_byte) begin
                        // Loading here makes cpuReadData valid in the same cycle as cpuDone.
                        if (!write_q) begin
                            rdata_d = word_d;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs decoded from state; all collapse to zero while reset holds the registers.
    always_comb begin
        memRequest     = 1'b0;
        memWriteEnable = 1'b0;
        cpuBusy        = (state_q != IDLE);
        cpuDone        = 1'b0;
        cpuError       = 1'b0;
        memAddr        = addr_q + ADDRESS_WIDTH'(idx_q);
        memDataOut     = wdata_q[idx_q*BUS_WIDTH +: BUS_WIDTH];
        cpuReadData    = rdata_q;
        case (state_q)
            ISSUE, WAIT_ACCEPT: begin
                memRequest     = 1'b1;
                memWriteEnable = write_q;
            end
            DONE: begin
                cpuDone  = 1'b1;
                cpuError = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_word_access_unit.sv
`timescale 1ns/1ps
module tb_word_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpuStart;
    logic        cpuWrite;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWriteData;
    logic [31:0] cpuReadData;
    logic        cpuBusy;
    logic        cpuDone;
    logic        cpuError;
    logic        memRequest;
    logic [31:0] memAddr;
    logic        memWriteEnable;
    logic [7:0]  memDataOut;
    logic [7:0]  memDataIn;
    logic        memBusy;

    word_access_unit #(
        .ADDRESS_WIDTH(32),
        .BUS_WIDTH(8),
        .WORD_BYTES(4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpuStart(cpuStart),
        .cpuWrite(cpuWrite),
        .cpuAddr(cpuAddr),
        .cpuWriteData(cpuWriteData),
        .cpuReadData(cpuReadData),
        .cpuBusy(cpuBusy),
        .cpuDone(cpuDone),
        .cpuError(cpuError),
        .memRequest(memRequest),
        .memAddr(memAddr),
        .memWriteEnable(memWriteEnable),
        .memDataOut(memDataOut),
        .memDataIn(memDataIn),
        .memBusy(memBusy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] obs_addr [4];
    logic        obs_we   [4];
    logic [7:0]  obs_dat  [4];
    int          obs_bad;
    int          obs_tmo;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise cpuStart for one cycle, then scramble the CPU inputs so only latched values can be used.
    task automatic start_access(input logic wr, input logic [31:0] a, input logic [31:0] d, output int c0);
        cpuWrite     = wr;
        cpuAddr      = a;
        cpuWriteData = d;
        cpuStart     = 1'b1;
        c0           = cyc;
        step();
        cpuStart     = 1'b0;
        cpuWrite     = ~wr;
        cpuAddr      = 32'h0BAD_0BAD;
        cpuWriteData = 32'h1234_5678;
    endtask

    // MMU stimulus for one byte: accept the cycle after the request, finish one cycle later.
    task automatic serve_byte(input int i, input logic [7:0] rd);
        int n;
        n = 0;
        while (memRequest !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (memRequest !== 1'b1) begin
            obs_tmo++;
            return;
        end
        obs_addr[i] = memAddr;
        obs_we[i]   = memWriteEnable;
        obs_dat[i]  = memDataOut;
        step();
        if (memRequest !== 1'b1 || memAddr !== obs_addr[i] ||
            memWriteEnable !== obs_we[i] || memDataOut !== obs_dat[i]) obs_bad++;
        memBusy = 1'b1;
        step();
        if (memRequest !== 1'b0 || memWriteEnable !== 1'b0) obs_bad++;
        memBusy   = 1'b0;
        memDataIn = rd;
        step();
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        cpuStart     = 1'b0;
        cpuWrite     = 1'b0;
        cpuAddr      = 32'h0;
        cpuWriteData = 32'h0;
        memDataIn    = 8'h0;
        memBusy      = 1'b0;
        #3;
        tests_run++;
        if ({cpuBusy, cpuDone, cpuError, memRequest, memWriteEnable} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {cpuBusy, cpuDone, cpuError, memRequest, memWriteEnable});
        end
        tests_run++;
        if (memAddr !== 32'h0 || memDataOut !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: addr %h data %h expected 0", memAddr, memDataOut);
        end
        tests_run++;
        if (cpuReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 0", cpuReadData);
        end
        step();
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (cpuBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: busy %b expected 0", cpuBusy);
        end
    endtask

    task automatic test_read();
        int c0;
        logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        obs_bad = 0;
        obs_tmo = 0;
        start_access(1'b0, 32'h100, 32'hFFFF_FFFF, c0);
        for (int i = 0; i < 4; i++) serve_byte(i, bytes[i]);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_addr[i] !== 32'h100 + i || obs_we[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL read_addr%0d: addr %h we %b expected %h we 0", i, obs_addr[i], obs_we[i], 32'h100 + i);
            end
        end
        tests_run++;
        if (obs_bad != 0 || obs_tmo != 0) begin
            tests_failed++;
            $display("FAIL read_handshake: bad %0d timeouts %0d expected 0 0", obs_bad, obs_tmo);
        end
        tests_run++;
        if (cpuDone !== 1'b1 || cpuError !== 1'b0 || cyc - c0 != 13) begin
            tests_failed++;
            $display("FAIL read_done: done %b err %b latency %0d expected 1 0 13", cpuDone, cpuError, cyc - c0);
        end
        tests_run++;
        if (cpuReadData !== 32'h4433_2211) begin
            tests_failed++;
            $display("FAIL read_data: got %h expected 44332211", cpuReadData);
        end
        step();
        tests_run++;
        if (cpuDone !== 1'b0 || cpuBusy !== 1'b0 || cpuReadData !== 32'h4433_2211) begin
            tests_failed++;
            $display("FAIL read_after: done %b busy %b data %h expected 0 0 44332211", cpuDone, cpuBusy, cpuReadData);
        end
    endtask

    task automatic test_write();
        int c0;
        logic [7:0] exp_dat [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        obs_bad = 0;
        obs_tmo = 0;
        start_access(1'b1, 32'h200, 32'hDEAD_BEEF, c0);
        for (int i = 0; i < 4; i++) serve_byte(i, 8'h55);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_addr[i] !== 32'h200 + i || obs_we[i] !== 1'b1 || obs_dat[i] !== exp_dat[i]) begin
                tests_failed++;
                $display("FAIL write_byte%0d: addr %h we %b data %h expected %h 1 %h",
                         i, obs_addr[i], obs_we[i], obs_dat[i], 32'h200 + i, exp_dat[i]);
            end
        end
        tests_run++;
        if (obs_bad != 0 || obs_tmo != 0) begin
            tests_failed++;
            $display("FAIL write_handshake: bad %0d timeouts %0d expected 0 0", obs_bad, obs_tmo);
        end
        tests_run++;
        if (cpuDone !== 1'b1 || cpuReadData !== 32'h4433_2211) begin
            tests_failed++;
            $display("FAIL write_done: done %b data %h expected 1 44332211", cpuDone, cpuReadData);
        end
        step();
    endtask

    task automatic test_wrap();
        int c0;
        logic [31:0] exp_addr [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        obs_bad = 0;
        obs_tmo = 0;
        start_access(1'b0, 32'hFFFF_FFFE, 32'h0, c0);
        for (int i = 0; i < 4; i++) serve_byte(i, 8'(i + 1));
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_addr[i] !== exp_addr[i]) begin
                tests_failed++;
                $display("FAIL wrap_addr%0d: got %h expected %h", i, obs_addr[i], exp_addr[i]);
            end
        end
        tests_run++;
        if (cpuDone !== 1'b1 || cpuReadData !== 32'h0403_0201) begin
            tests_failed++;
            $display("FAIL wrap_data: done %b data %h expected 1 04030201", cpuDone, cpuReadData);
        end
        step();
    endtask

    task automatic test_busy_start();
        int c0;
        int extra;
        obs_bad = 0;
        obs_tmo = 0;
        extra   = 0;
        start_access(1'b0, 32'h300, 32'h0, c0);
        serve_byte(0, 8'hC0);
        serve_byte(1, 8'hC1);
        cpuStart = 1'b1;
        cpuAddr  = 32'h900;
        cpuWrite = 1'b1;
        step();
        cpuStart = 1'b0;
        serve_byte(2, 8'hC2);
        serve_byte(3, 8'hC3);
        tests_run++;
        if (cpuDone !== 1'b1 || cpuReadData !== 32'hC3C2_C1C0) begin
            tests_failed++;
            $display("FAIL busy_done: done %b data %h expected 1 c3c2c1c0", cpuDone, cpuReadData);
        end
        // A start arriving during DONE is also ignored.
        cpuStart = 1'b1;
        step();
        cpuStart = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (cpuDone !== 1'b0 || cpuBusy !== 1'b0 || memRequest !== 1'b0) extra++;
            step();
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (obs_addr[i] !== 32'h300 + i || obs_we[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_addr%0d: addr %h we %b expected %h we 0", i, obs_addr[i], obs_we[i], 32'h300 + i);
            end
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL busy_ignored: %0d cycles of activity expected 0", extra);
        end
    endtask

    task automatic test_early_busy();
        int c0;
        obs_bad = 0;
        obs_tmo = 0;
        memBusy = 1'b1;
        start_access(1'b0, 32'h400, 32'h0, c0);
        tests_run++;
        if (memRequest !== 1'b1 || memAddr !== 32'h400) begin
            tests_failed++;
            $display("FAIL early_req: req %b addr %h expected 1 00000400", memRequest, memAddr);
        end
        step();
        tests_run++;
        if (memRequest !== 1'b0 || cpuBusy !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_single: req %b busy %b expected 0 1", memRequest, cpuBusy);
        end
        memBusy   = 1'b0;
        memDataIn = 8'hA1;
        step();
        for (int i = 1; i < 4; i++) serve_byte(i, 8'(8'hA1 + i));
        tests_run++;
        if (cpuDone !== 1'b1 || cpuReadData !== 32'hA4A3_A2A1 || obs_bad != 0 || obs_tmo != 0) begin
            tests_failed++;
            $display("FAIL early_data: done %b data %h bad %0d expected 1 a4a3a2a1 0", cpuDone, cpuReadData, obs_bad);
        end
        step();
    endtask

    task automatic test_timeout();
        int c0;
        int n;
        start_access(1'b0, 32'h600, 32'h0, c0);
`ifdef WORD_ACCESS_TIMEOUT_EN
        n = 0;
        while (cpuDone !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        tests_run++;
        if (cpuDone !== 1'b1 || cpuError !== 1'b1 || cyc - c0 != 66) begin
            tests_failed++;
            $display("FAIL timeout_done: done %b err %b latency %0d expected 1 1 66", cpuDone, cpuError, cyc - c0);
        end
        tests_run++;
        if (memRequest !== 1'b0 || cpuReadData !== 32'hA4A3_A2A1) begin
            tests_failed++;
            $display("FAIL timeout_state: req %b data %h expected 0 a4a3a2a1", memRequest, cpuReadData);
        end
        step();
        tests_run++;
        if (cpuError !== 1'b0 || cpuBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_after: err %b busy %b expected 0 0", cpuError, cpuBusy);
        end
`else
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (cpuBusy !== 1'b1 || cpuDone !== 1'b0 || cpuError !== 1'b0) n++;
            step();
        end
        tests_run++;
        if (n != 0) begin
            tests_failed++;
            $display("FAIL no_timeout: %0d cycles not busy-waiting expected 0", n);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        tests_run++;
        if (cpuBusy !== 1'b0 || cpuReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL no_timeout_recover: busy %b data %h expected 0 0", cpuBusy, cpuReadData);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c0;
        int extra;
        extra = 0;
        start_access(1'b0, 32'h500, 32'h0, c0);
        serve_byte(0, 8'h77);
        step();
        memBusy = 1'b1;
        step();
        tests_run++;
        if (memRequest !== 1'b0 || cpuBusy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_setup: req %b busy %b expected 0 1", memRequest, cpuBusy);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({cpuBusy, cpuDone, cpuError, memRequest, memWriteEnable} !== 5'b0 ||
            memAddr !== 32'h0 || memDataOut !== 8'h0 || cpuReadData !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: ctrl %b addr %h dout %h rdata %h expected all 0",
                     {cpuBusy, cpuDone, cpuError, memRequest, memWriteEnable}, memAddr, memDataOut, cpuReadData);
        end
        step();
        memBusy   = 1'b0;
        memDataIn = 8'hFF;
        step();
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (cpuDone !== 1'b0 || cpuBusy !== 1'b0 || memRequest !== 1'b0) extra++;
            step();
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++;
            $display("FAIL mid_release: %0d cycles of activity expected 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_wrap();
        test_busy_start();
        test_early_busy();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
